// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_reader_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } rd_state_t;

   localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/reader_skid_buf.sv
// Circular buffer holding captured FIFO words; head word is presented to the stream.
module reader_skid_buf #(
   parameter  int unsigned DATA_WIDTH = 8,
   parameter  int unsigned DEPTH      = 2,
   localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [OCC_W-1:0]      occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;

   // Explicit wrap keeps non-power-of-2 depths inside the array.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (clear) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= ptr_inc(tail);
         end
         if (pop) head <= ptr_inc(head);
         occ <= occ + OCC_W'(push) - OCC_W'(pop);
      end
   end

   assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO, re-presenting its words as a valid/ready stream.
// Optional stall counter output enabled by FIFO_READER_PERF_EN.
module fifo_stream_reader
   import fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SKID_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
   output logic                   fifo_r_en,
   input  logic                   flush,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   busy
`ifdef FIFO_READER_PERF_EN
  ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   rd_state_t        state_q;
   rd_state_t        state_d;
   logic [CNT_W-1:0] occ;
   logic [CNT_W-1:0] infl_q;
   logic [CNT_W-1:0] infl_d;
   logic             rd_pend_q;
   logic             pop;
   logic             issue;
   logic             buf_clear;
   logic             buf_push;
   logic [SUM_W-1:0] fill;

   assign pop  = m_valid & m_ready;
   assign fill = SUM_W'(occ) + SUM_W'(infl_q);

   // Reserve a slot for every word in flight; a same-cycle pop frees one.
   assign issue = rst_n & (state_q == RUN) & ~fifo_empty
                & (fill < SUM_W'(SKID_DEPTH) + SUM_W'(pop));
   assign fifo_r_en = issue;

   assign buf_clear = flush & (state_q == RUN);
   assign buf_push  = rd_pend_q & (state_q == RUN);
   assign m_valid   = (occ != '0);
   assign busy      = (state_q == FLUSH);

   reader_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SKID_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (buf_clear),
      .push      (buf_push),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (m_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         infl_q    <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         infl_q    <= infl_d;
         rd_pend_q <= issue;
      end
   end

   // FLUSH drains outstanding reads, discarding them, before reads resume.
   always_comb begin
      state_d = state_q;
      infl_d  = infl_q + CNT_W'(issue) - CNT_W'(rd_pend_q);
      case (state_q)
         RUN:   if (flush) state_d = FLUSH;
         FLUSH: if (infl_q == '0) state_d = RUN;
      endcase
   end

   occ_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
      fill <= SUM_W'(SKID_DEPTH));

`ifdef FIFO_READER_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (flush) begin
         stall_cnt <= '0;
      end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: FIFO model, stream scoreboard, directed tests.
module tb_fifo_stream_reader;

   logic       clk;
   logic       rst_n;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data = '0;
   logic       fifo_r_en;
   logic       flush;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       busy;
`ifdef FIFO_READER_PERF_EN
   logic [15:0] stall_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   fifo_stream_reader #(.DATA_WIDTH(8), .SKID_DEPTH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_r_en    (fifo_r_en),
      .flush        (flush),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .busy         (busy)
`ifdef FIFO_READER_PERF_EN
     ,.stall_cnt    (stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model: registered data_out, one-cycle read latency, not reset.
   logic [7:0]  mem [0:255];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_r_en && !fifo_empty) begin
         fifo_rd_data <= mem[rd_ptr[7:0]];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard: every granted word is delivered in order unless a flush or reset discards it.
   logic [7:0] exp_q [$];
   logic       hold_v = 1'b0;
   logic [7:0] hold_d = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         if (fifo_empty) chk("r_en_while_empty", 32'(fifo_r_en), 32'(0));
         if (hold_v) begin
            chk("hold_valid", 32'(m_valid), 32'(1));
            chk("hold_data", 32'(m_data), 32'(hold_d));
         end
         if (m_valid && m_ready) begin
            chk("beat_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) chk("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
         end
         if (fifo_r_en && !fifo_empty) exp_q.push_back(mem[rd_ptr[7:0]]);
         if (flush) exp_q.delete();
         hold_v = m_valid && !m_ready && !flush;
         hold_d = m_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wr_ptr[7:0]] = base + 8'(i);
         wr_ptr = wr_ptr + 1;
      end
   endtask

   task automatic wait_valid(input string name, input int limit);
      int n = 0;
      @(negedge clk);
      while (!m_valid && n < limit) begin
         tick();
         @(negedge clk);
         n++;
      end
      chk(name, 32'(m_valid), 32'(1));
   endtask

   task automatic drain_check(input string name, input int cycles);
      repeat (cycles) tick();
      @(negedge clk);
      chk({name, "_idle"}, 32'(m_valid), 32'(0));
      chk({name, "_all_delivered"}, 32'(exp_q.size()), 32'(0));
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_r_en", 32'(fifo_r_en), 32'(0));
      chk("rst_valid", 32'(m_valid), 32'(0));
      chk("rst_data", 32'(m_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
`ifdef FIFO_READER_PERF_EN
      chk("rst_stall_cnt", 32'(stall_cnt), 32'(0));
`endif
      tick();
      rst_n = 1'b1;
      tick();

      // Four words, always ready: reads on cycles 0..3, beats A1..A4 on cycles 2..5.
      load(4, 8'hA1);
      m_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("t1_r_en", 32'(fifo_r_en), 32'(k < 4));
         chk("t1_valid", 32'(m_valid), 32'(k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) chk("t1_data", 32'(m_data), 32'(8'hA1 + 8'(k - 2)));
         tick();
      end

      // Sixteen words back-to-back with no bubble.
      load(16, 8'h10);
      wait_valid("t2_first_beat", 6);
      for (int k = 0; k < 16; k++) begin
         chk("t2_no_bubble", 32'(m_valid), 32'(1));
         tick();
         @(negedge clk);
      end
      chk("t2_end", 32'(m_valid), 32'(0));
      drain_check("t2", 2);

      // Backpressure: reads stop at two outstanding, head held for five cycles.
      m_ready = 1'b0;
      load(8, 8'h30);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("t3_r_en", 32'(fifo_r_en), 32'(k < 2));
         chk("t3_valid", 32'(m_valid), 32'(k >= 2));
         if (k >= 2) chk("t3_data", 32'(m_data), 32'(8'h30));
         tick();
      end
      m_ready = 1'b1;
      drain_check("t3", 14);

      // Flush at steady state: beat 51 completes, 52/53 discarded, 54 follows.
      load(8, 8'h50);
      repeat (3) tick();
      flush = 1'b1;
      @(negedge clk);
      chk("t4_flush_beat_valid", 32'(m_valid), 32'(1));
      chk("t4_flush_beat_data", 32'(m_data), 32'(8'h51));
      tick();
      flush = 1'b0;
      for (int k = 4; k < 8; k++) begin
         @(negedge clk);
         chk("t4_busy", 32'(busy), 32'(k == 4 || k == 5));
         chk("t4_valid", 32'(m_valid), 32'(0));
         chk("t4_r_en", 32'(fifo_r_en), 32'(k == 6 || k == 7));
         tick();
      end
      @(negedge clk);
      chk("t4_resume_valid", 32'(m_valid), 32'(1));
      chk("t4_resume_data", 32'(m_data), 32'(8'h54));
      drain_check("t4", 6);

      // Flush with nothing in flight: exactly one cycle busy.
      flush = 1'b1;
      @(negedge clk);
      chk("t4b_busy0", 32'(busy), 32'(0));
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("t4b_busy1", 32'(busy), 32'(1));
      tick();
      @(negedge clk);
      chk("t4b_busy2", 32'(busy), 32'(0));
      tick();

      // Reset mid-stream with a word buffered and one in flight.
      load(8, 8'h70);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_r_en", 32'(fifo_r_en), 32'(0));
      chk("t5_rst_valid", 32'(m_valid), 32'(0));
      chk("t5_rst_data", 32'(m_data), 32'(0));
      chk("t5_rst_busy", 32'(busy), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      wait_valid("t5_first_beat", 5);
      chk("t5_first_data", 32'(m_data), 32'(8'h73));
      drain_check("t5", 8);

`ifdef FIFO_READER_PERF_EN
      // Seven stall cycles, then a flush clears the counter.
      m_ready = 1'b0;
      load(1, 8'h90);
      repeat (9) tick();
      @(negedge clk);
      chk("t6_stall_cnt", 32'(stall_cnt), 32'(7));
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("t6_stall_clear", 32'(stall_cnt), 32'(0));
      m_ready = 1'b1;
      drain_check("t6", 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
